// File: rtl/bcd_addsub_seq.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Operands are captured on start; outputs update together with a done pulse.
module bcd_addsub_seq #(
    parameter int DIGITS = 8,
    parameter int WIDTH  = 4 * DIGITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             err
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_q;
    logic             op_q;
    logic             c_q;
    logic             err_int_q;
    logic [CW-1:0]    k_q;

    logic [5:0]       s;
    logic [3:0]       dig;
    logic             c_nxt;
    logic [WIDTH-1:0] work_nxt;

    function automatic logic bad_digits(input logic [WIDTH-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Operands shift right, so the active digit is always at [3:0].
    always_comb begin
        s     = '0;
        dig   = '0;
        c_nxt = 1'b0;
        if (!op_q) begin
            s = {2'b0, a_q[3:0]} + {2'b0, b_q[3:0]} + {5'b0, c_q};
            if (s > 6'd9) begin
                dig   = 4'(s - 6'd10);
                c_nxt = 1'b1;
            end else begin
                dig = s[3:0];
            end
        end else begin
            s = {2'b0, a_q[3:0]} - {2'b0, b_q[3:0]} - {5'b0, c_q};
            if (s[5]) begin
                dig   = 4'(s + 6'd10);
                c_nxt = 1'b1;
            end else begin
                dig = s[3:0];
            end
        end
        work_nxt = WIDTH'({dig, work_q} >> 4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            work_q    <= '0;
            op_q      <= 1'b0;
            c_q       <= 1'b0;
            err_int_q <= 1'b0;
            k_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q       <= x;
                        b_q       <= y;
                        op_q      <= op;
                        k_q       <= '0;
                        c_q       <= 1'b0;
                        work_q    <= '0;
                        err_int_q <= bad_digits(x) | bad_digits(y);
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    a_q    <= a_q >> 4;
                    b_q    <= b_q >> 4;
                    c_q    <= c_nxt;
                    work_q <= work_nxt;
                    k_q    <= k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        err    <= err_int_q;
                        result <= err_int_q ? '0 : work_nxt;
                        cout   <= err_int_q ? 1'b0 : c_nxt;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
